// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding RV32I load/store unit sitting between a core request
//   channel and a single-port, combinational-read data memory.
//   Flow: IDLE (accept) -> ACCESS (one memory cycle) -> RESP (hold until taken).
//
// Parameters
//   MEM_BYTES   byte size of the attached memory, used for range checking
//
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses are
//                         reported as errors; otherwise they are performed at
//                         the unaligned byte address.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          1 = store / 0 = load, RV32I width/sign code
//   req_addr, req_wdata         byte address, store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        formatted load data (0 for stores/errors), error
//   mem_wen, mem_wmask          write enable and byte mask (ACCESS only)
//   mem_addr, mem_wdata         memory address and write data (0 outside ACCESS)
//   mem_rdata                   combinational little-endian read data
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        we_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        err_p0;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    // Illegal width code, out-of-range span or (optionally) misalignment.
    // The end address is formed in 33 bits so addresses near 0xFFFFFFFF
    // cannot wrap back into range.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic        illegal;
        logic        misal;
        logic [32:0] end_addr;
        if (we)
            illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        else
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end_addr = {1'b0, addr} + {30'd0, access_size(f3)};
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        access_err = illegal || misal || (end_addr > 33'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] rdata,
                                                input logic [2:0] f3);
        logic signed [31:0] res;
        case (f3)
            3'b000:  res = {{24{rdata[7]}}, rdata[7:0]};
            3'b001:  res = {{16{rdata[15]}}, rdata[15:0]};
            3'b100:  res = {24'd0, rdata[7:0]};
            3'b101:  res = {16'd0, rdata[15:0]};
            default: res = rdata;
        endcase
        load_format = res;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_mask = 4'b0001;
            2'b01:   store_mask = 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    assign req_ready  = rst_n && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign err_p0     = access_err(we_p0, funct3_p0, addr_p0);

    // ---- stage p0: request capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
        end
    end

    // Memory outputs decode from state alone, so an asynchronous reset
    // drops mem_wen in the same instant it forces IDLE.
    always_comb begin
        state_nxt = state;
        mem_wen   = 1'b0;
        mem_wmask = 4'b0000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_addr = addr_p0;
                if (we_p0) begin
                    mem_wdata = wdata_p0;
                    if (!err_p0) begin
                        mem_wen   = 1'b1;
                        mem_wmask = store_mask(funct3_p0);
                    end
                end
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: response capture (only in ACCESS, held through RESP) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ACCESS) begin
                resp_err   <= err_p0;
                resp_rdata <= (we_p0 || err_p0) ? 32'd0
                                                : load_format(mem_rdata, funct3_p0);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    logic [7:0] mem      [MEM_BYTES];  // memory as modified by the DUT
    logic [7:0] init_img [MEM_BYTES];  // starting image
    logic [7:0] ref_mem  [MEM_BYTES];  // memory as the model says it should be
    logic       load_img;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: combinational little-endian read, byte-masked write.
    // Bytes beyond the array read as zero and are never written.
    always_comb begin
        mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (({1'b0, mem_addr} + 33'(i)) < 33'(MEM_BYTES))
                mem_rdata[8*i +: 8] = mem[mem_addr + 32'(i)];
        end
    end

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_img[i];
        end else if (mem_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i] && (({1'b0, mem_addr} + 33'(i)) < 33'(MEM_BYTES)))
                    mem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        longint unsigned last;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1;
        last = longint'(a) + longint'(m_size(f3));
        if (last > longint'(MEM_BYTES)) return 1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % m_size(f3)) != 0) return 1;
`endif
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        longint unsigned v;
        int unsigned n;
        n = m_size(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a + 32'(i)]) << (8 * i);
        if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
            v = v + (64'h1_0000_0000 - (64'd1 << (8 * n)));
        return v[31:0];
    endfunction

    // One transaction from IDLE, returns observed response; stall = cycles of
    // resp_ready low while RESP is shown, with a competing req_valid held up.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er);
        bit          e;
        logic [31:0] exp_rd;
        int unsigned n;
        e = m_err(we, f3, a);
        n = m_size(f3);
        exp_rd = (we || e) ? 32'd0 : m_load(f3, a);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        check("acc_addr", mem_addr, a);
        check("acc_wen", {31'd0, mem_wen}, {31'd0, we && !e});
        check("acc_rvalid", {31'd0, resp_valid}, 32'd0);
        check("acc_ready", {31'd0, req_ready}, 32'd0);
        if (!we) check("acc_ld_mask", {28'd0, mem_wmask}, 32'd0);
        if (we && !e) begin
            check("acc_st_mask", {28'd0, mem_wmask}, (32'd1 << (4'(n))) - 32'd1);
            check("acc_wdata", mem_wdata, wd);
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        end
        @(posedge clk); #1;
        rd = resp_rdata;
        er = resp_err;
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_err", {31'd0, resp_err}, {31'd0, e});
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_memoff", {mem_wen, mem_wmask, 27'd0} | mem_addr | mem_wdata, 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'd0;
            @(posedge clk); #1;
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, exp_rd);
            check("stall_err", {31'd0, resp_err}, {31'd0, e});
            check("stall_ready", {31'd0, req_ready}, 32'd0);
            check("stall_wen", {31'd0, mem_wen}, 32'd0);
        end
        if (stall > 0) begin
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("back_idle_valid", {31'd0, resp_valid}, 32'd0);
        check("back_idle_wen", {31'd0, mem_wen}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          nbad;

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        load_img   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end

        // Reset state, with a request offered during reset
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_wen_mask", {27'd0, mem_wen, mem_wmask}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        load_img  = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rvalid", {31'd0, resp_valid}, 32'd0);

        // SW then the five load flavours over the same word
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_err", {31'd0, er}, 32'd0);
        txn(1'b0, 3'b000, 32'h10, 32'd0, 0, rd, er); check("lb_const", rd, 32'hFFFFFFEF);
        txn(1'b0, 3'b100, 32'h10, 32'd0, 0, rd, er); check("lbu_const", rd, 32'h000000EF);
        txn(1'b0, 3'b001, 32'h10, 32'd0, 0, rd, er); check("lh_const", rd, 32'hFFFFBEEF);
        txn(1'b0, 3'b101, 32'h10, 32'd0, 0, rd, er); check("lhu_const", rd, 32'h0000BEEF);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er); check("lw_const", rd, 32'hDEADBEEF);

        // Range edges, including addresses that would wrap in 32 bits
        txn(1'b0, 3'b010, 32'h3FD, 32'd0, 0, rd, er);
        check("lw3fd_err", {31'd0, er}, 32'd1);
        check("lw3fd_rdata", rd, 32'd0);
        txn(1'b0, 3'b010, 32'h3FC, 32'd0, 0, rd, er);
        check("lw3fc_err", {31'd0, er}, 32'd0);
        txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, rd, er);
        check("lw_wrap_err", {31'd0, er}, 32'd1);
        txn(1'b1, 3'b000, 32'hFFFFFFFF, 32'h55, 0, rd, er);
        check("sb_wrap_err", {31'd0, er}, 32'd1);

        // Illegal width codes
        txn(1'b0, 3'b011, 32'h20, 32'd0, 0, rd, er);
        check("ld011_err", {31'd0, er}, 32'd1);
        txn(1'b1, 3'b100, 32'h20, 32'h11223344, 0, rd, er);
        check("st100_err", {31'd0, er}, 32'd1);

        // Misaligned halfword store
        txn(1'b1, 3'b001, 32'h11, 32'hCAFE1234, 0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check("sh11_err", {31'd0, er}, 32'd1);
`else
        check("sh11_err", {31'd0, er}, 32'd0);
`endif

        // Back-pressure on the response
        txn(1'b0, 3'b010, 32'h10, 32'd0, 5, rd, er);

        // Reset during a store's ACCESS cycle
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = ~{ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]};
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstacc_wen_before", {31'd0, mem_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstacc_wen", {31'd0, mem_wen}, 32'd0);
        check("rstacc_maddr", mem_addr, 32'd0);
        check("rstacc_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("rstacc_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rstacc_nowrite", {mem[67], mem[66], mem[65], mem[64]},
              {ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]});
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstacc_no_resp", {31'd0, resp_valid}, 32'd0);
        end

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            logic        we;
            int          st;
            case ($urandom_range(0, 9))
                0:       a = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 7));
                1:       a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                2, 3:    a = 32'($urandom_range(0, MEM_BYTES - 1));
                default: a = 32'($urandom_range(0, 47));
            endcase
            we = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 2) == 0) f3[2] = f3[1:0] != 2'b10;
            st = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            txn(we, f3, a, $urandom, st, rd, er);
        end

        nbad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check("mem_image", 32'(nbad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
